systolic_seq_ctrl: RTL and testbench

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_pkg.sv | 27 ++
 rtl/skew_shift.sv | 36 +++
 rtl/systolic_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer: sequencer states, default
// array geometry and the k-index width derivation.
package systolic_pkg;

  localparam int N_DEF      = 4;
  localparam int K_MAX_DEF  = 256;
  localparam int PE_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Width needed to hold every k_len value from 0 up to and including k_max.
  function automatic int kw_of(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  // Cycles for the last injected operand to ripple to the far corner PE and settle.
  function automatic int drain_len(input int n, input int pe_lat);
    return 2 * (n - 1) + pe_lat;
  endfunction

endpackage

// File: rtl/skew_shift.sv
// Diagonal delay line for the systolic injection enables: lane i carries the
// input delayed by i cycles, lane 0 passes straight through.
module skew_shift
  import systolic_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         in_i,
  output logic [N-1:0] out_o
);

  if (N > 1) begin : g_dly
    logic [N-2:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q <= '0;
      end else if (clr_i) begin
        sr_q <= '0;
      end else begin
        sr_q[0] <= in_i;
        for (int i = 1; i < N - 1; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign out_o = {sr_q, in_i};
  end else begin : g_nodly
    assign out_o = in_i;
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile matmul sequencer for an N x N systolic array: CLEAR -> FEED -> DRAIN -> DONE.
// Define SYSTOLIC_SEQ_PERF_EN to get a busy-cycle counter on cycle_cnt.
// Handshake: start is a one-cycle request honoured only in IDLE (abort wins);
// done is a one-cycle pulse, busy is high from CLEAR through DRAIN.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int  N      = N_DEF,
  parameter int  K_MAX  = K_MAX_DEF,
  parameter int  PE_LAT = PE_LAT_DEF,
  localparam int KW     = kw_of(K_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  output logic          buf_rd_en,
  output logic [KW-1:0] buf_addr,
  output logic [N-1:0]  row_en,
  output logic          pe_clr,
  output logic          busy,
  output logic          done,
  output logic [31:0]   cycle_cnt,
  output state_e        dbg_state
);

  localparam int DRAIN = drain_len(N, PE_LAT);
  localparam int DW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   addr_q;
  logic [DW-1:0]   drain_q;
  logic            rd_q;
  logic            feed_q;
  logic            clr_q;
  logic            busy_q;
  logic            done_q;

  logic [KW-1:0]   k_sat_d;
  logic            feed_last;
  logic            drain_last;
  logic            run_abort;

  assign k_sat_d    = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign feed_last  = (addr_q == k_q - KW'(1));
  assign drain_last = (drain_q == DW'(DRAIN - 1));
  // busy_q is high exactly in CLEAR/FEED/DRAIN, the states abort may cut short.
  assign run_abort  = abort && busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      rd_q    <= 1'b0;
      feed_q  <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      if (run_abort) begin
        state_q <= S_IDLE;
        addr_q  <= '0;
        drain_q <= '0;
        rd_q    <= 1'b0;
        feed_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              k_q     <= k_sat_d;
              state_q <= S_CLEAR;
              clr_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          S_CLEAR: begin
            if (k_q == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FEED;
              rd_q    <= 1'b1;
              feed_q  <= 1'b1;
              addr_q  <= '0;
            end
          end
          S_FEED: begin
            if (feed_last) begin
              state_q <= S_DRAIN;
              rd_q    <= 1'b0;
              feed_q  <= 1'b0;
              addr_q  <= '0;
              drain_q <= '0;
            end else begin
              addr_q <= addr_q + KW'(1);
            end
          end
          S_DRAIN: begin
            if (drain_last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q + DW'(1);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  skew_shift #(.N(N)) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (run_abort),
    .in_i  (feed_q),
    .out_o (row_en)
  );

  assign buf_rd_en = rd_q;
  assign buf_addr  = addr_q;
  assign pe_clr    = clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] run_cnt_q;
  logic [31:0] cycle_cnt_q;
  logic        go_done;

  assign go_done = !abort &&
                   (((state_q == S_CLEAR) && (k_q == '0)) ||
                    ((state_q == S_DRAIN) && drain_last));

  // The final busy cycle is counted as the result is captured, so cycle_cnt
  // is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        run_cnt_q <= '0;
      end else if (busy_q) begin
        run_cnt_q <= run_cnt_q + 32'd1;
      end
      if (go_done) begin
        cycle_cnt_q <= run_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: cycle-accurate trace model plus a
// scoreboard of expected done cycles and operand addresses.
module tb_systolic_seq_ctrl;
  import systolic_pkg::*;

  localparam int N      = 4;
  localparam int K_MAX  = 256;
  localparam int PE_LAT = 1;
  localparam int KW     = 9;
  localparam int D      = 2 * (N - 1) + PE_LAT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          abort = 1'b0;
  logic          buf_rd_en;
  logic [KW-1:0] buf_addr;
  logic [N-1:0]  row_en;
  logic          pe_clr;
  logic          busy;
  logic          done;
  logic [31:0]   cycle_cnt;
  state_e        dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0]   done_exp_q[$];
  logic [KW-1:0] addr_exp_q[$];

  systolic_seq_ctrl #(.N(N), .K_MAX(K_MAX), .PE_LAT(PE_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .abort     (abort),
    .buf_rd_en (buf_rd_en),
    .buf_addr  (buf_addr),
    .row_en    (row_en),
    .pe_clr    (pe_clr),
    .busy      (busy),
    .done      (done),
    .cycle_cnt (cycle_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({dbg_state, pe_clr, busy, done, buf_rd_en, row_en, buf_addr});
  endfunction

  function automatic logic feed_at(input int c, input int keff);
    return (keff > 0) && (c >= 2) && (c <= 1 + keff);
  endfunction

  // Expected output vector c cycles after the accepting edge of start.
  function automatic logic [31:0] model_vec(input int c, input int keff, input int last);
    state_e        st;
    logic [N-1:0]  re;
    logic [KW-1:0] ad;
    for (int i = 0; i < N; i++) re[i] = feed_at(c - i, keff);
    ad = feed_at(c, keff) ? KW'(c - 2) : '0;
    if (c == 1)                st = S_CLEAR;
    else if (feed_at(c, keff)) st = S_FEED;
    else if (c < last)         st = S_DRAIN;
    else if (c == last)        st = S_DONE;
    else                       st = S_IDLE;
    return 32'({st, (c == 1), (c >= 1 && c < last), (c == last), feed_at(c, keff), re, ad});
  endfunction

  // Scoreboard: every done pulse and every operand read must match the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (done_exp_q.size() == 0) check("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else                        check("done_cycle", 32'(cyc), done_exp_q.pop_front());
      end
      if (buf_rd_en === 1'b1) begin
        if (addr_exp_q.size() == 0) check("rd_unexpected", 32'(buf_addr), 32'hFFFF_FFFF);
        else                        check("buf_addr", 32'(buf_addr), 32'(addr_exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_addrs(input int n);
    for (int a = 0; a < n; a++) addr_exp_q.push_back(KW'(a));
  endtask

  // Runs one tile and compares every cycle to the model; s1/s2 pulse a stray
  // start during those cycles (0 = none).
  task automatic run_trace(input int k, input int s1, input int s2);
    int keff, last, c0;
    keff = (k > K_MAX) ? K_MAX : k;
    last = (keff == 0) ? 2 : 2 + keff + D;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    c0    = cyc;
    done_exp_q.push_back(32'(c0 + last));
    push_addrs(keff);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      check($sformatf("trace_k%0d_c%0d", k, c), out_vec(), model_vec(c, keff, last));
      start = ((c == s1) || (c == s2));
    end
    start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("reset_outputs", out_vec(), 32'd0);
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", out_vec(), 32'd0);

    // Basic run, k_len=0 shortcut, perf counter run, saturated depth.
    run_trace(3, 0, 0);
`ifdef SYSTOLIC_SEQ_PERF_EN
    check("cycle_cnt_k3", cycle_cnt, 32'd11);
`else
    check("cycle_cnt_k3", cycle_cnt, 32'd0);
`endif
    run_trace(0, 0, 0);
    run_trace(5, 0, 0);
`ifdef SYSTOLIC_SEQ_PERF_EN
    check("cycle_cnt_k5", cycle_cnt, 32'd13);
`else
    check("cycle_cnt_k5", cycle_cnt, 32'd0);
`endif
    run_trace(300, 0, 0);
`ifdef SYSTOLIC_SEQ_PERF_EN
    check("cycle_cnt_sat", cycle_cnt, 32'd264);
`else
    check("cycle_cnt_sat", cycle_cnt, 32'd0);
`endif

    // Stray starts in FEED and in the DONE cycle are ignored.
    run_trace(2, 2, 2 + 2 + D);
    @(negedge clk);
    check("no_restart_after_done", out_vec(), 32'd0);

    // Abort in the second FEED cycle of a k_len=8 run.
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(8);
    push_addrs(2);
    @(negedge clk);
    start = 1'b0;
    check("abort_pre_clear", 32'(pe_clr), 32'd1);
    @(negedge clk);
    check("abort_pre_feed0", 32'(row_en), 32'd1);
    @(negedge clk);
    check("abort_pre_feed1", 32'(row_en), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    check("abort_outputs", out_vec(), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_settled", out_vec(), 32'd0);

    // Abort wins over start in the same IDLE cycle.
    start = 1'b1;
    abort = 1'b1;
    k_len = KW'(4);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", out_vec(), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_start_still_idle", out_vec(), 32'd0);

    // Asynchronous reset in the middle of DRAIN.
    start = 1'b1;
    k_len = KW'(1);
    push_addrs(1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_state", 32'(dbg_state), 32'(S_DRAIN));
    check("drain_row_en", 32'(row_en), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", out_vec(), 32'd0);
    check("rst_mid_cycle_cnt", cycle_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_mid_settled", out_vec(), 32'd0);

    check("done_queue_empty", 32'(done_exp_q.size()), 32'd0);
    check("addr_queue_empty", 32'(addr_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
